// File: rtl/shape_select_filter.sv
// shape_select_filter: debounces per-frame classifier results into a frame-aligned shape_select,
// falling back to no shape when the classifier stays silent for too many frames.
module shape_select_filter #(
    parameter int STABLE_COUNT   = 3,
    parameter int TIMEOUT_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       class_valid,
    input  logic [1:0] class_id,
    output logic       class_ready,
    output logic [1:0] shape_select,
    output logic       commit_pending,
    output logic       update_pulse
);
    localparam int AW = $clog2(STABLE_COUNT + 1);
    localparam int IW = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [AW-1:0] SC = AW'(STABLE_COUNT);
    localparam logic [IW-1:0] TF = IW'(TIMEOUT_FRAMES);
    localparam logic [0:0] TRACK   = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;

    logic [0:0]    state;
    logic [1:0]    candidate;
    logic [AW-1:0] agree_cnt, agree_nxt;
    logic [IW-1:0] idle_frames, idle_nxt;
    logic          accept;

    assign class_ready    = (state == TRACK) && !reset;
    assign commit_pending = (state == PENDING);
    assign accept         = class_valid && class_ready;

    // both counters saturate so a long run or long silence never wraps
    always_comb begin
        agree_nxt = (class_id != candidate) ? AW'(1) : (agree_cnt == SC) ? SC : agree_cnt + 1'b1;
        idle_nxt  = (idle_frames == TF) ? TF : idle_frames + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= TRACK;
            shape_select <= '0;
            candidate    <= '0;
            agree_cnt    <= '0;
            idle_frames  <= '0;
            update_pulse <= 1'b0;
        end else begin
            update_pulse <= 1'b0;
            if (state == PENDING) begin
                if (frame_start) begin
                    shape_select <= candidate;
                    agree_cnt    <= '0;
                    idle_frames  <= '0;
                    state        <= TRACK;
                    update_pulse <= 1'b1;
                end
            end else if (accept) begin
                candidate   <= class_id;
                agree_cnt   <= agree_nxt;
                idle_frames <= '0;
                if (agree_nxt == SC && class_id != shape_select)
                    state <= PENDING;
            end else if (frame_start) begin
                // once already at shape 0 the idle count just sits saturated
                if (idle_nxt == TF && shape_select != 2'd0) begin
                    shape_select <= '0;
                    candidate    <= '0;
                    agree_cnt    <= '0;
                    idle_frames  <= '0;
                    update_pulse <= 1'b1;
                end else begin
                    idle_frames <= idle_nxt;
                end
            end
        end
    end
endmodule
